// File: rtl/pwm_multi_controller.sv
// rtl/pwm_multi_controller.sv - multi-channel PWM with shared period counter and double-buffered duty registers
module pwm_multi_controller #(
  parameter int CW_WIDTH = 17,
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                center_mode,
  input  logic                period_wr,
  input  logic [CW_WIDTH-1:0] period_in,
  input  logic                cw_wr,
  input  logic [CH_IDX_W-1:0] cw_ch,
  input  logic [CW_WIDTH-1:0] cw_in,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_start,
  output logic [CW_WIDTH-1:0] count_out
);

  localparam logic [CW_WIDTH-1:0] ONE = CW_WIDTH'(1);

  // Shadow (software-visible) and active (in-use) copies of period and duty words.
  logic [CW_WIDTH-1:0] shadow_period;
  logic [CW_WIDTH-1:0] active_period;
  logic [CW_WIDTH-1:0] shadow_cw [NUM_CH];
  logic [CW_WIDTH-1:0] active_cw [NUM_CH];

  logic [CW_WIDTH-1:0] count;
  logic                dir_down;
  logic                active_mode;
  logic                en_q;

  logic forced_bnd;
  logic p_zero;
  logic edge_bnd;
  logic center_bnd;
  logic boundary;
  logic start_at_one;

  // First enabled cycle after idle forces a reload so a fresh period starts from the shadows.
  assign forced_bnd = enable & ~en_q;
  assign p_zero     = (active_period == '0);
  assign edge_bnd   = ~active_mode & (count == active_period - ONE);
  assign center_bnd = active_mode & dir_down & (count == '0);
  assign boundary   = enable & (forced_bnd | p_zero | edge_bnd | center_bnd);

  // In center mode the count==0 boundary cycle is also the first cycle of the next
  // triangle, so a center-to-center reload resumes at 1 to keep the period at 2P.
  assign start_at_one = center_bnd & ~forced_bnd & ~p_zero & center_mode &
                        (shadow_period != '0);

  assign count_out = count;

  // Shadow registers take writes on any edge, whether or not the counter runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_cw[i] <= '0;
      end
    end else begin
      if (period_wr) begin
        shadow_period <= period_in;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cw_wr && (int'(cw_ch) == i)) begin
          shadow_cw[i] <= cw_in;
        end
      end
    end
  end

  // Counter, direction, reload of active registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      dir_down      <= 1'b0;
      active_period <= '0;
      active_mode   <= 1'b0;
      en_q          <= 1'b0;
      period_start  <= 1'b0;
      pwm_out       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        active_cw[i] <= '0;
      end
    end else begin
      en_q <= enable;
      if (!enable) begin
        count        <= '0;
        dir_down     <= 1'b0;
        period_start <= 1'b0;
        pwm_out      <= '0;
      end else begin
        period_start <= boundary;
        // The forced reload cycle is not part of any period, so outputs stay low for it.
        for (int i = 0; i < NUM_CH; i++) begin
          pwm_out[i] <= ~forced_bnd & ~p_zero & (active_cw[i] > count);
        end
        if (boundary) begin
          active_period <= shadow_period;
          active_mode   <= center_mode;
          for (int i = 0; i < NUM_CH; i++) begin
            active_cw[i] <= shadow_cw[i];
          end
          dir_down <= 1'b0;
          count    <= start_at_one ? ONE : '0;
        end else if (active_mode) begin
          if (!dir_down) begin
            if (count >= active_period) begin
              dir_down <= 1'b1;
              count    <= count - ONE;
            end else begin
              count <= count + ONE;
            end
          end else begin
            count <= count - ONE;
          end
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: doc/pwm_multi_controller.md
Name: pwm_multi_controller

Overview:
- Parametrised multi-channel PWM generator. Successor to the single-channel 17-bit comparator/free-running-counter PWM block.
- Adds the following over the single-channel block:
  - N channels sharing one programmable-period counter.
  - Double-buffered (shadow/active) duty registers, updated glitch-free at period boundaries.
  - Edge-aligned or center-aligned counting.
  - Enable control and a period-start strobe.
- Sits between the control/register logic and the motor/LED/actuator pins of the package-monitor system.

Parameters:
- CW_WIDTH, 17, width of the counter, period and duty (compare) words.
- NUM_CH, 4, number of PWM channels (1..16).
- CH_IDX_W, 2, width of the channel-select field. Must be ≥ clog2(NUM_CH), and ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run counter; 0 = counter and outputs held idle.
- center_mode  in  1  0 = edge-aligned (sawtooth); 1 = center-aligned (triangle). Sampled only at period boundary.
- period_wr  in  1  write strobe for the shadow period register.
- period_in  in  CW_WIDTH  new period value.
- cw_wr  in  1  write strobe for one channel's shadow duty register.
- cw_ch  in  CH_IDX_W  target channel of cw_wr. Writes with index ≥ NUM_CH are ignored.
- cw_in  in  CW_WIDTH  new duty (compare) value.
- pwm_out  out  NUM_CH  PWM outputs, registered.
- period_start  out  1  one-cycle pulse in the cycle the active registers are reloaded.
- count_out  out  CW_WIDTH  current counter value, for debug/sync.

Behaviour:
- Reset (async, rst_n=0): all of the following clear to 0 immediately:
  - count, direction, pwm_out, period_start.
  - All shadow and active registers.
  - Latched mode.
- Shadow writes: period_wr and cw_wr update shadow registers at the next clk edge, independent of enable. Both may be asserted in the same cycle.
- Boundary (reload) event:
  - Edge mode: the cycle where count == active_period-1.
  - Center mode: the cycle where count == 0 while counting down (see Center mode).
  - At the boundary, active_period, all active_cw[i] and the mode are loaded from the shadows at that edge, and period_start=1 for that one cycle.
  - A shadow write coinciding with the boundary edge is NOT taken; the previous shadow value is loaded, and the new value applies from the next boundary.
- Edge mode: count runs 0,1,…,P-1, then wraps to 0 (P = active_period).
- Center mode: count runs 0 up to P, then down to 1, then 0 (boundary), giving a 2P-cycle period.
- Compare: pwm_out[i] <= (active_cw[i] > count), registered, one-cycle latency relative to count.
  - cw=0 gives constant 0.
  - cw ≥ P (edge mode) gives constant 1.
  - Center mode: pulse is symmetric about count==0, high for 2*min(cw,P) - 1 cycles, and constant 1 if cw > P.
- P == 0: counter held at 0 and pwm_out held 0. A boundary is still signalled every cycle, so a new period loads on the next edge.
- Enable:
  - enable=0: count=0, direction=up, pwm_out=0, period_start=0.
  - 0→1 transition: in the first enabled cycle, active registers load from the shadows (forced boundary, period_start=1) and count starts at 0.
- Mode change mid-period takes effect only at the next boundary. Count direction resets to up on reload.
- Widths: all counter arithmetic is unsigned in CW_WIDTH bits. P = 2^CW_WIDTH-1 is legal, and center mode must not overflow count.

Test Plan:
- Reset check: rst_n=0 asserted mid-run with count≈50 → pwm_out=0, count_out=0 and period_start=0 immediately, with no clock edge needed.
- Edge mode: P=10, cw0=3, cw1=0, cw2=10, cw3=7 → per 10-cycle period:
  - ch0 high 3 cycles.
  - ch1 always low.
  - ch2 always high.
  - ch3 high 7 cycles.
  - period_start pulses every 10 cycles.
- Double buffering: running P=10, cw0=3. Write cw0=8 at count=4 → current period keeps 3-cycle high, next period gives 8-cycle high, with no glitch. A write landing exactly on the boundary edge is delayed one further period.
- Center mode: P=8, cw0=2, center_mode=1 → 16-cycle period, ch0 high 3 cycles centered on count==0, period_start every 16 cycles.
- Period change: P=10 → 4 written mid-period, and P=0 → old period completes before the change. With P=0, outputs stay 0. Rewriting P=5 resumes 5-cycle periods after one reload.
- Enable toggle: enable dropped mid-period → pwm_out=0 and count=0 next cycle. Re-enable → period_start pulse in the first cycle, and a fresh period starts from count 0 with the updated shadows.
